// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// State encoding and the divide-by-zero quotient pattern.
package div_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] FIXUP = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Wide enough for the largest legal WIDTH; sliced at the user.
  localparam logic [63:0] DBZ_Q = '1;

endpackage

// File: rtl/seq_divider_step.sv
// One combinational restoring-division iteration.
// Shifts {prem, shreg} left and conditionally subtracts the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] prem,
  input  logic [WIDTH-1:0] shreg,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH-1:0] prem_next,
  output logic [WIDTH-1:0] shreg_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Trial subtraction; the top bit of trial is the borrow.
  always_comb begin
    shifted    = {prem, shreg[WIDTH-1]};
    trial      = shifted - {1'b0, dmag};
    shreg_next = {shreg[WIDTH-2:0], ~trial[WIDTH]};
    prem_next  = trial[WIDTH] ? shifted[WIDTH-1:0]
                              : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Signed/unsigned per request, divide-by-zero flag, valid/ready on both sides.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] dmag;
  logic [WIDTH-1:0] prem_next;
  logic [WIDTH-1:0] shreg_next;
  logic             neg_q;
  logic             neg_r;
  logic             accept;
  logic             dvd_neg;
  logic             dvs_neg;

  assign accept  = in_valid && in_ready;
  assign dvd_neg = is_signed && dividend[WIDTH-1];
  assign dvs_neg = is_signed && divisor[WIDTH-1];

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .prem      (prem),
    .shreg     (shreg),
    .dmag      (dmag),
    .prem_next (prem_next),
    .shreg_next(shreg_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:
        if (in_valid)
          state_next = (divisor == '0) ? DONE : CALC;
      CALC:
        if (cnt == CNT_W'(1)) state_next = FIXUP;
      FIXUP:
        state_next = DONE;
      DONE:
        if (out_ready) state_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Operand capture, iteration and sign fix-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      prem        <= '0;
      shreg       <= '0;
      dmag        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (accept) begin
            if (divisor != '0) begin
              neg_q       <= dvd_neg ^ dvs_neg;
              neg_r       <= dvd_neg;
              shreg       <= dvd_neg ? -dividend : dividend;
              dmag        <= dvs_neg ? -divisor : divisor;
              prem        <= '0;
              cnt         <= CNT_W'(WIDTH);
              div_by_zero <= 1'b0;
            end else begin
              quotient    <= DBZ_Q[WIDTH-1:0];
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        CALC: begin
          prem  <= prem_next;
          shreg <= shreg_next;
          cnt   <= cnt - CNT_W'(1);
        end
        FIXUP: begin
          quotient  <= neg_q ? -shreg : shreg;
          remainder <= neg_r ? -prem : prem;
        end
        DONE: ;
      endcase
    end
  end

endmodule
